// File: rtl/versa_pkg.sv
// Shared constants and types for the VERSA violation sink.
// Violation source indices, FSM states, register offsets and the saturating COUNT helper.
package versa_pkg;

  localparam int VIOL_ATOM   = 0;
  localparam int VIOL_IRQDMA = 1;
  localparam int VIOL_RPGPIO = 2;
  localparam int VIOL_RPEKEY = 3;
  localparam int VIOL_WPEKEY = 4;
  localparam int VIOL_WPCTR  = 5;

  localparam int COUNT_W = 8;

  localparam logic [13:0] REG_CAUSE  = 14'd0;
  localparam logic [13:0] REG_LASTPC = 14'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/versa_rst_hold_cnt.sv
// Hold counter that times the cpu_rst pulse; done flags the last asserted cycle.
// Cleared on episode start, counts while enabled, stops at HOLD_CYCLES-1 so it never wraps.
module versa_rst_hold_cnt #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/versa_violation_sink.sv
// Turns VERSA property violations into a fixed-length CPU reset pulse and logs cause, PC and count.
// The log survives puc so post-reset software can read it; only secure-ROM code may clear it.
module versa_violation_sink
  import versa_pkg::*;
#(
  parameter int          HOLD_CYCLES = 16,
  parameter int          NUM_SRC     = 6,
  parameter logic [15:0] SMEM_BASE   = 16'hA000,
  parameter logic [15:0] SMEM_SIZE   = 16'h4000,
  parameter logic [13:0] PER_ADDR    = 14'h00C8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] viol,
  input  logic [15:0]        pc,
  input  logic               puc,
  input  logic               per_en,
  input  logic [1:0]         per_we,
  input  logic [13:0]        per_addr,
  input  logic [15:0]        per_din,
  output logic [15:0]        per_dout,
  output logic               cpu_rst,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   cause_q, cause_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [15:0]          last_pc_q, last_pc_d;

  logic any_viol;
  logic ep_start;
  logic hold_done;
  logic in_smem;
  logic log_wr;
  logic unused_din;

  assign any_viol   = |viol;
  assign unused_din = ^{per_din[15:9], per_din[7:6]};

  // Widened compare so a secure region ending at the top of memory still works.
  assign in_smem = ({1'b0, pc} >= {1'b0, SMEM_BASE}) &&
                   ({1'b0, pc} <  ({1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE}));
  assign log_wr  = per_en && (|per_we) && (per_addr == PER_ADDR + REG_CAUSE) && in_smem;

  always_comb begin
    state_d  = state_q;
    ep_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_viol) begin
          state_d  = ASSERT;
          ep_start = 1'b1;
        end
      end
      ASSERT: begin
        if (hold_done) state_d = RELEASE;
      end
      RELEASE: begin
        if (any_viol) begin
          state_d  = ASSERT;
          ep_start = 1'b1;
        end else if (!puc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  versa_rst_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (ep_start),
    .en     (state_q == ASSERT),
    .done   (hold_done)
  );

  // Clear first, then set/increment, so a same-cycle violation or episode wins.
  always_comb begin
    cause_d   = cause_q;
    count_d   = count_q;
    last_pc_d = last_pc_q;
    if (log_wr && per_we[0]) cause_d = cause_d & ~per_din[NUM_SRC-1:0];
    if (log_wr && per_we[1] && per_din[8]) count_d = '0;
    cause_d = cause_d | viol;
    if (ep_start) begin
      count_d   = sat_inc(count_d);
      last_pc_d = pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign cpu_rst = (state_q == ASSERT);
  assign busy    = (state_q != IDLE);

  always_comb begin
    per_dout = '0;
    if (per_en && (per_we == 2'b00)) begin
      if (per_addr == PER_ADDR + REG_CAUSE) begin
        per_dout = {count_q, 2'b00, 6'(cause_q)};
      end else if (per_addr == PER_ADDR + REG_LASTPC) begin
        per_dout = last_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_versa_violation_sink.sv
// Directed plus randomized bench for versa_violation_sink against an episode-level reference model.
module tb_versa_violation_sink;

  localparam int          HOLD = 16;
  localparam logic [13:0] A_CAUSE = 14'h00C8;
  localparam logic [13:0] A_LPC   = 14'h00C9;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  viol = '0;
  logic [15:0] pc = '0;
  logic        puc = 1'b0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic [15:0] per_dout;
  logic        cpu_rst;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int rst_cnt = 0;
  logic [15:0] last_rd;

  // Reference model: remaining reset cycles, release flag and the software-visible log.
  int          m_hold = 0;
  bit          m_rel = 1'b0;
  logic [5:0]  m_cause = '0;
  logic [7:0]  m_count = '0;
  logic [15:0] m_lpc = '0;

  versa_violation_sink dut (
    .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .puc(puc),
    .per_en(per_en), .per_we(per_we), .per_addr(per_addr), .per_din(per_din),
    .per_dout(per_dout), .cpu_rst(cpu_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mexp(input logic [13:0] a);
    if (a == A_CAUSE) return {m_count, 2'b00, m_cause};
    if (a == A_LPC)   return m_lpc;
    return 16'h0000;
  endfunction

  task automatic model_clear();
    m_hold = 0; m_rel = 1'b0; m_cause = '0; m_count = '0; m_lpc = '0;
  endtask

  task automatic step();
    bit wr;
    bit start;
    @(posedge clk);
    wr = per_en && (per_we != 2'b00) && (per_addr == A_CAUSE) &&
         (pc >= 16'hA000) && (pc < 16'hE000);
    if (wr && per_we[0]) m_cause = m_cause & ~per_din[5:0];
    if (wr && per_we[1] && per_din[8]) m_count = 8'h00;
    m_cause = m_cause | viol;
    start = 1'b0;
    if (m_hold > 0) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) m_rel = 1'b1;
    end else if (m_rel) begin
      if (viol != 0) start = 1'b1;
      else if (!puc) m_rel = 1'b0;
    end else if (viol != 0) begin
      start = 1'b1;
    end
    if (start) begin
      m_hold = HOLD;
      m_rel = 1'b0;
      if (m_count != 8'hFF) m_count = m_count + 8'h01;
      m_lpc = pc;
    end
    #1;
    chk("cpu_rst", 32'(cpu_rst), 32'(m_hold > 0));
    chk("busy", 32'(busy), 32'((m_hold > 0) || m_rel));
    if (cpu_rst) rst_cnt++;
  endtask

  task automatic rd(input logic [13:0] a, input logic [15:0] exp, input string tag);
    per_en = 1'b1; per_we = 2'b00; per_addr = a;
    #1;
    last_rd = per_dout;
    chk(tag, 32'(per_dout), 32'(exp));
    per_en = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [1:0] we, input logic [15:0] d,
                    input logic [15:0] p);
    per_en = 1'b1; per_we = we; per_addr = a; per_din = d; pc = p;
    step();
    per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic wait_release();
    for (int i = 0; i < 100; i++) begin
      if (busy && !cpu_rst) break;
      step();
    end
    chk("release_reached", 32'(busy && !cpu_rst), 32'd1);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rd(A_CAUSE, 16'h0000, "rst_cause");
    rd(A_LPC, 16'h0000, "rst_lpc");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // Single violation
    rst_cnt = 0;
    pc = 16'hE010; viol = 6'b000001;
    step();
    viol = '0;
    wait_release();
    chk("single_len", 32'(rst_cnt), 32'd16);
    rd(A_CAUSE, 16'h0101, "single_cause_count");
    rd(A_LPC, 16'hE010, "single_lpc");
    step();
    chk("single_idle", 32'(busy), 32'd0);

    // Protected clear
    wr(A_CAUSE, 2'b11, 16'h013F, 16'hE000);
    rd(A_CAUSE, 16'h0101, "clear_outside_smem");
    wr(A_LPC, 2'b11, 16'hFFFF, 16'hA100);
    rd(A_LPC, 16'hE010, "lpc_write_ignored");
    wr(A_CAUSE, 2'b11, 16'h013F, 16'hA100);
    rd(A_CAUSE, 16'h0000, "clear_inside_smem");

    // Violation storm inside one episode
    rst_cnt = 0;
    pc = 16'h1234; viol = 6'b000100;
    step();
    viol = '0;
    repeat (4) step();
    pc = 16'h5555; viol = 6'b100000;
    step();
    viol = '0;
    wait_release();
    chk("storm_len", 32'(rst_cnt), 32'd16);
    rd(A_CAUSE, 16'h0124, "storm_cause_count");
    rd(A_LPC, 16'h1234, "storm_lpc");

    // Re-entry from RELEASE while puc holds
    puc = 1'b1;
    repeat (2) step();
    rst_cnt = 0;
    pc = 16'h4321; viol = 6'b001000;
    step();
    viol = '0;
    wait_release();
    chk("reentry_len", 32'(rst_cnt), 32'd16);
    rd(A_CAUSE, 16'h022C, "reentry_cause_count");
    rd(A_LPC, 16'h4321, "reentry_lpc");
    puc = 1'b0;
    step();

    // Saturation over 256 episodes
    for (int e = 0; e < 256; e++) begin
      viol = 6'($urandom_range(1, 63)); pc = 16'($urandom);
      step();
      viol = '0;
      wait_release();
      step();
    end
    rd(A_CAUSE, mexp(A_CAUSE), "sat_model");
    chk("sat_count", 32'(last_rd[15:8]), 32'hFF);

    // W1C of bit 4 colliding with a new bit-4 violation
    per_en = 1'b1; per_we = 2'b01; per_addr = A_CAUSE; per_din = 16'h0010;
    pc = 16'hA200; viol = 6'b010000;
    step();
    per_en = 1'b0; per_we = 2'b00; viol = '0;
    rd(A_CAUSE, mexp(A_CAUSE), "collision_model");
    chk("collision_bit4", 32'(last_rd[4]), 32'd1);
    wait_release();
    step();

    // COUNT clear in the same cycle as an episode start
    per_en = 1'b1; per_we = 2'b10; per_addr = A_CAUSE; per_din = 16'h0100;
    pc = 16'hA300; viol = 6'b000001;
    step();
    per_en = 1'b0; per_we = 2'b00; viol = '0;
    rd(A_CAUSE, mexp(A_CAUSE), "clr_start_model");
    chk("clr_start_count", 32'(last_rd[15:8]), 32'd1);

    // Async reset at hold count 7
    repeat (7) step();
    chk("pre_reset_cpu_rst", 32'(cpu_rst), 32'd1);
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("areset_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    rd(A_CAUSE, 16'h0000, "areset_cause");
    rd(A_LPC, 16'h0000, "areset_lpc");
    reset_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [13:0] ra;
      viol = ($urandom_range(0, 11) == 0) ? 6'($urandom) : 6'b0;
      puc  = 1'($urandom);
      pc   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hA000, 16'hDFFF))
                                         : 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        per_en   = 1'b1;
        per_we   = 2'($urandom);
        per_addr = ($urandom_range(0, 3) == 0) ? A_LPC : A_CAUSE;
        per_din  = 16'($urandom);
      end
      step();
      per_en = 1'b0; per_we = 2'b00; viol = '0;
      case ($urandom_range(0, 2))
        0:       ra = A_CAUSE;
        1:       ra = A_LPC;
        default: ra = 14'($urandom);
      endcase
      rd(ra, mexp(ra), "rand_read");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
